montgomery_to_mont: RTL
=======================

// Module: montgomery_to_mont
// PURPOSE
//  Converts a conventional residue into the Montgomery domain: y = a*2^m_size mod m (R = 2^m_size).
//  Sits directly upstream of montgomery_mul; montgomery_from_conv performs the inverse conversion.
//  Uses iterative shift-and-conditional-subtract, so no precomputed R^2 mod m is needed.
//  Processes PBITS doublings per cycle.
// PARAMETERS
//  NBITS  2048  operand / modulus width
//  PBITS  1     modular doublings per SHIFT cycle (1..NBITS)
// PORTS
//  clk         input   1                  clock, all logic on rising edge
//  rst         input   1                  synchronous reset, active-high
//  enable_p    input   1                  start pulse, sampled only in IDLE
//  a           input   NBITS              conventional operand, captured on start
//  m           input   NBITS              modulus (odd, >1), captured on start
//  m_size      input   $clog2(NBITS)+3    R exponent (bit length of m), 0..NBITS, captured on start
//  y           output  NBITS              Montgomery-domain result a*R mod m
//  busy        output  1                  high from the cycle after start until done_irq_p inclusive
//  done_irq_p  output  1                  one-cycle pulse, y valid from this cycle
// BEHAVIOUR
//  Reset: state=IDLE; y=0, busy=0, done_irq_p=0; internal r, m_q, count cleared.
//  Reset overrides any state: an aborted run produces no done_irq_p, and y reads 0.
//  FSM IDLE -> PRE -> SHIFT -> DONE -> IDLE.
//  - IDLE:  when enable_p=1, capture a, m, m_size into r, m_q, count=m_size; go to PRE.
//  - PRE (1 cycle):   if r >= m_q then r <= r - m_q (one subtraction only, so a < 2m is supported).
//    If count==0, go directly to DONE; otherwise go to SHIFT.
//  - SHIFT: k = min(PBITS, count) chained steps per cycle.
//    Each step: t = {r,1'b0} (NBITS+1 bits); r <= (t >= {1'b0,m_q}) ? t - m_q : t.
//    Then count -= k. Go to DONE when count reaches 0.
//  - DONE (1 cycle):  y <= r (visible in the same cycle); done_irq_p=1; return to IDLE.
//  Latency:
//  - With enable_p sampled at edge T0, done_irq_p is high in the cycle after edge T0+1+ceil(m_size/PBITS)+1.
//  - Total: ceil(m_size/PBITS)+2 cycles. m_size=0 gives 2 cycles.
//  Arithmetic rules:
//  - Compare/subtract is NBITS+1 bits wide. Invariant r < m_q is held after each step.
//  - No overflow for m_q up to 2^NBITS-1.
//  Inputs and outputs:
//  - y holds its value until the next DONE or reset. a, m and m_size may change after start without effect.
//  - enable_p during PRE/SHIFT/DONE is ignored, with no queueing.
//  - enable_p in the same cycle as rst is ignored.
//  Preconditions (not checked): m odd and > 1, a < 2m, m_size <= NBITS.
//  - If m=0 or a >= 2m, the FSM still completes with the same latency, but y is unspecified.
// TESTING
//  1 NBITS=16,PBITS=1: m=13,m_size=4,a=5 -> y=2 (80 mod 13), done_irq_p exactly 6 cycles after start, 1 cycle wide.
//  2 a=15,m=13,m_size=4 (PRE reduction) -> y=6. a=0 -> y=0. a=12 -> y=10.
//  3 m=16'hFFFF,m_size=16,a=16'hFFFE -> y=16'hFFFE (2^16 = 1 mod m). Checks the NBITS+1 compare path.
//  4 PBITS=4, m=13,m_size=5,a=7 -> y=3 (224 mod 13) after ceil(5/4)+2=4 cycles. m_size=0,a=9 -> y=9 after 2 cycles.
//  5 enable_p re-pulsed mid-SHIFT with new a -> ignored, result from original a, single done pulse.
//  6 rst asserted mid-SHIFT -> next cycle IDLE, y=0, busy=0, no done_irq_p; a fresh start then gives the correct y.
//  Random: 10k vectors at NBITS=64, PBITS in {1,3,8}, compared against the a*2^m_size mod m reference model.

Source files
------------

// File: rtl/montgomery_to_mont.sv
// Converts a conventional residue into the Montgomery domain: y = a * 2^m_size mod m.
// Iterative modular doubling, PBITS doublings per SHIFT cycle; no R^2 mod m precompute needed.
module montgomery_to_mont #(
    parameter int NBITS = 2048,
    parameter int PBITS = 1,
    localparam int CW = $clog2(NBITS) + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] m,
    input  logic [CW-1:0]    m_size,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CW-1:0] PB_C = CW'(PBITS);

    state_t           state_q, state_d;
    logic [NBITS-1:0] r_q, r_d;
    logic [NBITS-1:0] mod_q, mod_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NBITS-1:0] y_q, y_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] r_v;

    // One modular doubling; the compare runs one bit wider so 2r never wraps.
    function automatic logic [NBITS-1:0] mod_dbl(input logic [NBITS-1:0] rv,
                                                 input logic [NBITS-1:0] mv);
        logic [NBITS:0] t;
        logic [NBITS:0] mm;
        t  = {rv, 1'b0};
        mm = {1'b0, mv};
        if (t >= mm) begin
            t = t - mm;
        end
        return t[NBITS-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            mod_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
            state_q <= state_d;
            r_q     <= r_d;
            mod_q   <= mod_d;
            count_q <= count_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        r_d     = r_q;
        mod_d   = mod_q;
        count_d = count_q;
        y_d     = y_q;
        done_d  = 1'b0;
        r_v     = r_q;

        unique case (state_q)
            IDLE: begin
                if (enable_p) begin
                    r_d     = a;
                    mod_d   = m;
                    count_d = m_size;
                    state_d = PRE;
                end
            end
            PRE: begin
                // Single reduction brings any a < 2m into range before doubling starts.
                if (r_q >= mod_q) begin
                    r_d = r_q - mod_q;
                end
                state_d = (count_q == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                for (int i = 0; i < PBITS; i++) begin
                    if (CW'(i) < count_q) begin
                        r_v = mod_dbl(r_v, mod_q);
                    end
                end
                r_d = r_v;
                if (count_q > PB_C) begin
                    count_d = count_q - PB_C;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                y_d     = r_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign y          = y_q;
    assign done_irq_p = done_q;
    assign busy       = (state_q != IDLE) || done_q;

endmodule
